// File: rtl/nav_autopilot.sv
// nav_autopilot
//   Closed-loop waypoint controller feeding three per-axis position
//   integrators. A command either cruises toward the target with a clamped
//   per-axis step each cycle, or charges for JUMP_CHARGE cycles and then
//   loads the target through jump_position for one cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    waypoint handshake (accepted only in IDLE)
//   cmd_jump                 1 = jump path, 0 = sublight path
//   cmd_target               target {z,y,x}, k bits per axis
//   abort                    cancel the active command (ignored in IDLE)
//   pos                      current position {z,y,x} from the integrators
//   pos_mode                 one-hot: 0010 integrate, 0100 jump load
//   jump_position            jump load value {z,y,x} (registered target)
//   velocity_x/_y/_z         signed per-axis velocity
//   busy                     high whenever not IDLE
//   arrived                  one-cycle pulse after successful completion
module nav_autopilot #(
  parameter int k           = 16,
  parameter int MAX_STEP    = 4,
  parameter int JUMP_CHARGE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_jump,
  input  logic [3*k-1:0]      cmd_target,
  input  logic                abort,
  input  logic [3*k-1:0]      pos,
  output logic [3:0]          pos_mode,
  output logic [3*k-1:0]      jump_position,
  output logic signed [k-1:0] velocity_x,
  output logic signed [k-1:0] velocity_y,
  output logic signed [k-1:0] velocity_z,
  output logic                busy,
  output logic                arrived
);

  localparam int CW = $clog2(JUMP_CHARGE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(JUMP_CHARGE - 1);
  localparam logic signed [k-1:0] STEP_MAX = k'(MAX_STEP);
  localparam logic signed [k-1:0] STEP_MIN = -STEP_MAX;
  localparam logic [3:0] MODE_INTEG = 4'b0010;
  localparam logic [3:0] MODE_JUMP  = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRUISE,
    S_CHARGE,
    S_JUMP,
    S_SETTLE
  } state_t;

  state_t         state_q, state_d;
  logic [3*k-1:0] target_q, target_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           arrived_q, arrived_d;

  logic signed [k-1:0] step_v [3];
  logic signed [k-1:0] vel    [3];
  logic                at_target;
  logic                accept;

  // Saturate a signed wrapped distance to +/-MAX_STEP.
  function automatic logic signed [k-1:0] clamp_step(input logic signed [k-1:0] d);
    if (d > STEP_MAX)      return STEP_MAX;
    else if (d < STEP_MIN) return STEP_MIN;
    else                   return d;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign at_target = (pos == target_q);

  // Difference is taken mod 2^k and read as signed, so each axis follows
  // the shortest wrapped path; -2^(k-1) resolves to the negative direction.
  always_comb begin
    logic [k-1:0] diff;
    diff = '0;
    for (int a = 0; a < 3; a++) begin
      diff      = target_q[a*k +: k] - pos[a*k +: k];
      step_v[a] = clamp_step($signed(diff));
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    arrived_d = 1'b0;
    pos_mode  = MODE_INTEG;
    for (int a = 0; a < 3; a++) vel[a] = '0;

    unique case (state_q)
      S_IDLE: begin
        // abort is deliberately not consulted here: it must not block an accept.
        if (accept) begin
          target_d = cmd_target;
          if (cmd_jump) begin
            state_d = S_CHARGE;
            cnt_d   = '0;
          end else begin
            state_d = S_CRUISE;
          end
        end
      end
      S_CRUISE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (at_target) begin
          state_d   = S_IDLE;
          arrived_d = 1'b1;
        end else begin
          for (int a = 0; a < 3; a++) vel[a] = step_v[a];
        end
      end
      S_CHARGE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_JUMP;
        end
      end
      S_JUMP: begin
        // The load is committed once in this state, even if abort arrives.
        pos_mode = MODE_JUMP;
        state_d  = abort ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (at_target) begin
          state_d   = S_IDLE;
          arrived_d = 1'b1;
        end else begin
          state_d = S_CRUISE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      arrived_q <= arrived_d;
    end
  end

  assign jump_position = target_q;
  assign velocity_x    = vel[0];
  assign velocity_y    = vel[1];
  assign velocity_z    = vel[2];
  assign busy          = (state_q != S_IDLE);
  assign arrived       = arrived_q;

endmodule

// File: tb/tb_nav_autopilot.sv
// Bench for nav_autopilot: a behavioural position integrator closes the loop,
// a table of per-cycle vectors carries inputs and expected outputs, and each
// vector's expectation passes through a scoreboard queue to the sampling point.
module tb_nav_autopilot;

  localparam logic [3:0] M_S = 4'b0010;
  localparam logic [3:0] M_J = 4'b0100;

  localparam logic [47:0] T_A  = {16'd65533, 16'd0,   16'd10};
  localparam logic [47:0] P_B  = {16'd65533, 16'd0,   16'd65534};
  localparam logic [47:0] T_B  = {16'd65533, 16'd0,   16'd2};
  localparam logic [47:0] T_C  = {16'd100,   16'd100, 16'd100};
  localparam logic [47:0] T_D  = {16'd0,     16'd0,   16'd50};
  localparam logic [47:0] T_D2 = {16'd100,   16'd100, 16'd104};
  localparam logic [47:0] T_E  = {16'd100,   16'd100, 16'd112};
  localparam logic [47:0] T_F  = {16'd100,   16'd100, 16'd0};
  localparam logic [47:0] T_G  = {16'd100,   16'd100, 16'd200};
  localparam logic [47:0] P_H  = {16'd100,   16'd100, 16'd197};

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_jump, abort;
  logic [47:0] cmd_target, pos_q, jump_position;
  logic [3:0]  pos_mode;
  logic [15:0] velocity_x, velocity_y, velocity_z;
  logic        busy, arrived;
  logic        pos_set;
  logic [47:0] pos_val;

  always #5 clk = ~clk;

  nav_autopilot #(.k(16), .MAX_STEP(4), .JUMP_CHARGE(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_jump(cmd_jump),
    .cmd_target(cmd_target), .abort(abort), .pos(pos_q),
    .pos_mode(pos_mode), .jump_position(jump_position),
    .velocity_x(velocity_x), .velocity_y(velocity_y), .velocity_z(velocity_z),
    .busy(busy), .arrived(arrived)
  );

  // Position integrators; pos_set lets the bench place the craft directly.
  always @(posedge clk or posedge rst) begin
    if (rst)                    pos_q <= '0;
    else if (pos_set)           pos_q <= pos_val;
    else if (pos_mode == M_J)   pos_q <= jump_position;
    else                        pos_q <= {pos_q[47:32] + velocity_z,
                                          pos_q[31:16] + velocity_y,
                                          pos_q[15:0]  + velocity_x};
  end

  typedef struct {
    logic        valid;
    logic        jump;
    logic [47:0] tgt;
    logic        abt;
    logic        setp;
    logic [47:0] pval;
    logic [15:0] vx, vy, vz;
    logic [3:0]  mode;
    logic        busy;
    logic        arr;
    logic        rdy;
    logic [47:0] jp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected outputs for a cycle spent in IDLE.
  function automatic void idle(input logic valid, input logic jump, input logic [47:0] tgt,
                               input logic abt, input logic arr, input logic [47:0] jp,
                               input logic setp = 1'b0, input logic [47:0] pval = '0);
    vec_t v;
    v.valid = valid; v.jump = jump; v.tgt = tgt; v.abt = abt; v.setp = setp; v.pval = pval;
    v.vx = '0; v.vy = '0; v.vz = '0; v.mode = M_S;
    v.busy = 1'b0; v.arr = arr; v.rdy = 1'b1; v.jp = jp;
    vecs.push_back(v);
  endfunction

  // Expected outputs for a cycle spent in any busy state.
  function automatic void act(input logic [15:0] vx, input logic [15:0] vy, input logic [15:0] vz,
                              input logic [3:0] mode, input logic [47:0] jp,
                              input logic abt = 1'b0, input logic valid = 1'b0,
                              input logic [47:0] tgt = '0,
                              input logic setp = 1'b0, input logic [47:0] pval = '0);
    vec_t v;
    v.valid = valid; v.jump = 1'b0; v.tgt = tgt; v.abt = abt; v.setp = setp; v.pval = pval;
    v.vx = vx; v.vy = vy; v.vz = vz; v.mode = mode;
    v.busy = 1'b1; v.arr = 1'b0; v.rdy = 1'b0; v.jp = jp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp, input int idx);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_vec(input vec_t e, input int idx);
    chk("velocity_x", 48'(velocity_x), 48'(e.vx), idx);
    chk("velocity_y", 48'(velocity_y), 48'(e.vy), idx);
    chk("velocity_z", 48'(velocity_z), 48'(e.vz), idx);
    chk("pos_mode", 48'(pos_mode), 48'(e.mode), idx);
    chk("busy", 48'(busy), 48'(e.busy), idx);
    chk("arrived", 48'(arrived), 48'(e.arr), idx);
    chk("cmd_ready", 48'(cmd_ready), 48'(e.rdy), idx);
    chk("jump_position", jump_position, e.jp, idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_jump = 1'b0; cmd_target = '0;
    abort = 1'b0; pos_set = 1'b0; pos_val = '0;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", 48'(cmd_ready), 48'd0, -1);
    chk("rst pos_mode", 48'(pos_mode), 48'(M_S), -1);
    chk("rst busy", 48'(busy), 48'd0, -1);
    chk("rst velocity_x", 48'(velocity_x), 48'd0, -1);
    chk("rst velocity_z", 48'(velocity_z), 48'd0, -1);
    chk("rst arrived", 48'(arrived), 48'd0, -1);
    chk("rst jump_position", jump_position, 48'd0, -1);
    rst = 1'b0;
    #1;
    chk("post-rst cmd_ready", 48'(cmd_ready), 48'd1, -1);

    // rst in the middle of CHARGE discards the pending jump.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_jump = 1'b1; cmd_target = T_C;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_jump = 1'b0; cmd_target = '0;
    @(posedge clk); #1;
    chk("charge busy", 48'(busy), 48'd1, -2);
    chk("charge jump_position", jump_position, T_C, -2);
    rst = 1'b1;
    #1;
    chk("mid-rst pos_mode", 48'(pos_mode), 48'(M_S), -2);
    chk("mid-rst velocity_y", 48'(velocity_y), 48'd0, -2);
    chk("mid-rst busy", 48'(busy), 48'd0, -2);
    chk("mid-rst cmd_ready", 48'(cmd_ready), 48'd0, -2);
    chk("mid-rst jump_position", jump_position, 48'd0, -2);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no jump after rst", 48'(pos_mode), 48'(M_S), -3);
      chk("idle after rst", 48'(busy), 48'd0, -3);
    end
    chk("ready after rst", 48'(cmd_ready), 48'd1, -3);

    // Sublight: pos 0 -> (10, 0, -3).
    idle(1, 0, T_A, 0, 0, 48'd0);
    act(16'd4, 16'd0, 16'hFFFD, M_S, T_A);
    act(16'd4, 16'd0, 16'd0, M_S, T_A);
    act(16'd2, 16'd0, 16'd0, M_S, T_A);
    act(16'd0, 16'd0, 16'd0, M_S, T_A);
    idle(0, 0, 48'd0, 0, 1, T_A);
    idle(0, 0, 48'd0, 0, 0, T_A);
    // Wrap: x 65534 -> 2 moves +4.
    idle(0, 0, 48'd0, 0, 0, T_A, 1'b1, P_B);
    idle(1, 0, T_B, 0, 0, T_A);
    act(16'd4, 16'd0, 16'd0, M_S, T_B);
    act(16'd0, 16'd0, 16'd0, M_S, T_B);
    idle(0, 0, 48'd0, 0, 1, T_B);
    // Jump: 8 CHARGE, 1 JUMP, SETTLE, arrived 10 cycles after accept.
    idle(1, 1, T_C, 0, 0, T_B);
    for (int i = 0; i < 8; i++) act(16'd0, 16'd0, 16'd0, M_S, T_C);
    act(16'd0, 16'd0, 16'd0, M_J, T_C);
    act(16'd0, 16'd0, 16'd0, M_S, T_C);
    idle(0, 0, 48'd0, 0, 1, T_C);
    idle(0, 0, 48'd0, 0, 0, T_C);
    // Abort on the third CHARGE cycle, then an immediate new command.
    idle(1, 1, T_D, 0, 0, T_C);
    act(16'd0, 16'd0, 16'd0, M_S, T_D);
    act(16'd0, 16'd0, 16'd0, M_S, T_D);
    act(16'd0, 16'd0, 16'd0, M_S, T_D, 1'b1);
    idle(1, 0, T_D2, 0, 0, T_D);
    act(16'd4, 16'd0, 16'd0, M_S, T_D2);
    act(16'd0, 16'd0, 16'd0, M_S, T_D2);
    idle(0, 0, 48'd0, 0, 1, T_D2);
    // Commands offered during CRUISE are ignored.
    idle(1, 0, T_E, 0, 0, T_D2);
    act(16'd4, 16'd0, 16'd0, M_S, T_E, 1'b0, 1'b1, 48'd0);
    act(16'd4, 16'd0, 16'd0, M_S, T_E, 1'b0, 1'b1, 48'd0);
    act(16'd0, 16'd0, 16'd0, M_S, T_E);
    idle(0, 0, 48'd0, 0, 1, T_E);
    idle(0, 0, 48'd0, 0, 0, T_E);
    // Abort in IDLE does not block accept; target == pos completes in 1 cycle;
    // negative clamp; abort in CRUISE forces velocity 0 with no arrival.
    idle(1, 0, T_E, 1, 0, T_E);
    act(16'd0, 16'd0, 16'd0, M_S, T_E);
    idle(0, 0, 48'd0, 0, 1, T_E);
    idle(1, 0, T_F, 0, 0, T_E);
    act(16'hFFFC, 16'd0, 16'd0, M_S, T_F);
    act(16'd0, 16'd0, 16'd0, M_S, T_F, 1'b1);
    idle(0, 0, 48'd0, 0, 0, T_F);
    // Abort during JUMP: the load still happens, no arrival.
    idle(1, 1, T_G, 0, 0, T_F);
    for (int i = 0; i < 8; i++) act(16'd0, 16'd0, 16'd0, M_S, T_G);
    act(16'd0, 16'd0, 16'd0, M_J, T_G, 1'b1);
    idle(0, 0, 48'd0, 0, 0, T_G);
    idle(0, 0, 48'd0, 0, 0, T_G);
    // Jump to the current position runs the full sequence; the landing is
    // displaced so SETTLE falls back to CRUISE for the last 3 units.
    idle(1, 1, T_G, 0, 0, T_G);
    for (int i = 0; i < 8; i++) act(16'd0, 16'd0, 16'd0, M_S, T_G);
    act(16'd0, 16'd0, 16'd0, M_J, T_G, 1'b0, 1'b0, 48'd0, 1'b1, P_H);
    act(16'd0, 16'd0, 16'd0, M_S, T_G);
    act(16'd3, 16'd0, 16'd0, M_S, T_G);
    act(16'd0, 16'd0, 16'd0, M_S, T_G);
    idle(0, 0, 48'd0, 0, 1, T_G);
    idle(0, 0, 48'd0, 0, 0, T_G);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      cmd_valid  = vecs[i].valid;
      cmd_jump   = vecs[i].jump;
      cmd_target = vecs[i].tgt;
      abort      = vecs[i].abt;
      pos_set    = vecs[i].setp;
      pos_val    = vecs[i].pval;
      sb.push_back(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard empty at step %0d", i);
      end else begin
        e = sb.pop_front();
        check_vec(e, i);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
